// File: rtl/moldudp64_encoder.sv
// MoldUDP64 downstream packet builder: 20-byte header plus length-prefixed messages, byte-packed into 64-bit beats.
// Optional idle heartbeat packets are compiled in when MOLD_HEARTBEAT_EN is defined.
module moldudp64_encoder #(
  parameter logic [31:0] HB_CYCLES = 32'd1000000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [79:0]  sessionID,
  input  logic [63:0]  seqInit,
  input  logic         seqLoad,
  input  logic         pktValid,
  output logic         pktReady,
  input  logic [15:0]  pktMsgCount,
  input  logic         msgValid,
  output logic         msgReady,
  input  logic [63:0]  msgData,
  input  logic [3:0]   msgBytes,
  input  logic [15:0]  msgLen,
  input  logic         msgLast,
  output logic [63:0]  dataOut,
  output logic [3:0]   outBytes,
  output logic         outValid,
  input  logic         outReady,
  output logic         outLast,
  output logic [63:0]  sequenceNumber
);

  localparam int unsigned BUF_BYTES  = 16;
  localparam int unsigned BEAT_BYTES = 8;
  localparam int unsigned OCC_W      = 5;

  typedef enum logic [2:0] {
    S_IDLE, S_HDR0, S_HDR1, S_HDR2, S_LEN, S_DATA, S_FLUSH
  } state_e;

  state_e                  state_q, state_d;
  logic [8*BUF_BYTES-1:0]  buf_q, buf_d;
  logic [OCC_W-1:0]        occ_q, occ_d;
  logic [63:0]             seq_q, seq_d;
  logic [79:0]             session_q, session_d;
  logic [15:0]             count_q, count_d;
  logic [15:0]             remaining_q, remaining_d;

  logic                    can_push;
  logic                    pop;
  logic                    hb_fire;
  logic [3:0]              push_n;
  logic [3:0]              pop_n;
  logic [3:0]              msg_n;
  logic [3:0]              out_bytes_c;
  logic [63:0]             push_data;
  logic [63:0]             push_mask;
  logic [OCC_W-1:0]        base;
  logic [159:0]            hdr;

  assign can_push       = (occ_q <= OCC_W'(BEAT_BYTES));
  assign out_bytes_c    = (occ_q >= OCC_W'(BEAT_BYTES)) ? 4'd8 : occ_q[3:0];
  assign outValid       = (occ_q >= OCC_W'(BEAT_BYTES)) || ((state_q == S_FLUSH) && (occ_q != '0));
  assign outLast        = (state_q == S_FLUSH) && (occ_q != '0) && (occ_q <= OCC_W'(BEAT_BYTES));
  assign outBytes       = out_bytes_c;
  assign dataOut        = buf_q[63:0];
  assign sequenceNumber = seq_q;
  assign pop            = outValid && outReady;
  assign pop_n          = pop ? out_bytes_c : 4'd0;
  assign msg_n          = (msgBytes > 4'd8) ? 4'd8 : msgBytes;
  assign hdr            = {count_q, seq_q, session_q};

`ifdef MOLD_HEARTBEAT_EN
  logic [31:0] idle_cnt_q, idle_cnt_d;

  assign hb_fire = (state_q == S_IDLE) && (occ_q == '0) && (idle_cnt_q >= HB_CYCLES);

  // Idle counter: advances only while nothing is requested, cleared by any packet.
  always_comb begin
    idle_cnt_d = idle_cnt_q;
    if ((state_q != S_IDLE) || hb_fire) begin
      idle_cnt_d = '0;
    end else if (!pktValid) begin
      idle_cnt_d = idle_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      idle_cnt_q <= '0;
    end else begin
      idle_cnt_q <= idle_cnt_d;
    end
  end
`else
  logic unused_hb;
  assign unused_hb = ^HB_CYCLES;
  assign hb_fire   = 1'b0;
`endif

  // Packer: drop popped bytes from the front, append pushed bytes after what remains.
  always_comb begin
    push_mask = (push_n >= 4'd8) ? '1 : ((64'd1 << {push_n, 3'b000}) - 64'd1);
    base      = occ_q - OCC_W'(pop_n);
    buf_d     = (buf_q >> {pop_n, 3'b000}) | ((128'(push_data & push_mask)) << {base, 3'b000});
    occ_d     = occ_q + OCC_W'(push_n) - OCC_W'(pop_n);
  end

  // Packet sequencing: header, then LEN/DATA per message, then drain.
  always_comb begin
    state_d     = state_q;
    seq_d       = seq_q;
    session_d   = session_q;
    count_d     = count_q;
    remaining_d = remaining_q;
    push_n      = 4'd0;
    push_data   = 64'd0;
    pktReady    = 1'b0;
    msgReady    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (seqLoad) begin
          seq_d = seqInit;
        end
        pktReady = rst && (occ_q == '0) && !seqLoad && !hb_fire;
        if (hb_fire) begin
          session_d   = sessionID;
          count_d     = 16'd0;
          remaining_d = 16'd0;
          state_d     = S_HDR0;
        end else if (pktValid && pktReady) begin
          session_d   = sessionID;
          count_d     = pktMsgCount;
          remaining_d = pktMsgCount;
          state_d     = S_HDR0;
        end
      end
      S_HDR0: begin
        if (can_push) begin
          push_n    = 4'd8;
          push_data = hdr[63:0];
          state_d   = S_HDR1;
        end
      end
      S_HDR1: begin
        if (can_push) begin
          push_n    = 4'd8;
          push_data = hdr[127:64];
          state_d   = S_HDR2;
        end
      end
      S_HDR2: begin
        if (can_push) begin
          push_n    = 4'd4;
          push_data = {32'd0, hdr[159:128]};
          state_d   = (remaining_q == 16'd0) ? S_FLUSH : S_LEN;
        end
      end
      S_LEN: begin
        // Length prefix is taken from the first beat without consuming it.
        if (msgValid && can_push) begin
          push_n    = 4'd2;
          push_data = {48'd0, msgLen};
          state_d   = S_DATA;
        end
      end
      S_DATA: begin
        msgReady = rst && can_push;
        if (msgValid && can_push) begin
          push_n    = msg_n;
          push_data = msgData;
          if (msgLast) begin
            remaining_d = remaining_q - 16'd1;
            state_d     = (remaining_q == 16'd1) ? S_FLUSH : S_LEN;
          end
        end
      end
      S_FLUSH: begin
        if (outLast && pop) begin
          seq_d   = seq_q + 64'(count_q);
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      buf_q       <= '0;
      occ_q       <= '0;
      seq_q       <= '0;
      session_q   <= '0;
      count_q     <= '0;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      buf_q       <= buf_d;
      occ_q       <= occ_d;
      seq_q       <= seq_d;
      session_q   <= session_d;
      count_q     <= count_d;
      remaining_q <= remaining_d;
    end
  end

endmodule
